// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core slice: feeder FSM states and the canonical NOP.
package riscv_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // ADDI x0,x0,0
  localparam logic [31:0] RV_NOP = 32'h00000013;

endpackage

// File: rtl/riscv_instr_buf.sv
// Program buffer: DEPTH x WIDTH register array, one synchronous write port,
// one asynchronous read port. Contents are deliberately not reset.
module riscv_instr_buf #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Store one program word per write-enabled cycle
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/riscv_instr_feeder.sv
// Instruction stream source: loads a program into a small buffer while idle and
// plays it back to the core under a valid/ready handshake, once or looped.
module riscv_instr_feeder
  import riscv_pkg::*;
#(
  parameter int unsigned     WIDTH  = 32,
  parameter int unsigned     DEPTH  = 16,
  parameter logic [WIDTH-1:0] BUBBLE = WIDTH'(RV_NOP),
  localparam int unsigned    CW     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             clear,
  input  logic             start,
  input  logic             loop_en,
  input  logic             stop,
  input  logic             instr_ready,
  output logic [WIDTH-1:0] instr_out,
  output logic             instr_valid,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [CW-1:0]    count,
  output logic [15:0]      iter_cnt
);

  localparam int unsigned    AW   = $clog2(DEPTH);
  localparam logic [CW-1:0]  FULL = CW'(DEPTH);

  state_t           state, state_nxt;
  logic [AW-1:0]    rd_ptr, rd_nxt;
  logic [CW-1:0]    count_nxt;
  logic [15:0]      iter_nxt;
  logic             ovf_nxt, loop_q, loop_nxt, done_nxt;
  logic             buf_we;
  logic [WIDTH-1:0] buf_rdata;
  logic [WIDTH-1:0] out_nxt;
  logic             last;

  riscv_instr_buf #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (AW'(count)),
    .wdata (wr_data),
    .raddr (rd_nxt),
    .rdata (buf_rdata)
  );

  assign last = (rd_ptr == AW'(count - CW'(1)));

  // Next-state, pointer, counter and output computation
  always_comb begin
    state_nxt = state;
    rd_nxt    = rd_ptr;
    count_nxt = count;
    iter_nxt  = iter_cnt;
    ovf_nxt   = ovf;
    loop_nxt  = loop_q;
    done_nxt  = 1'b0;
    buf_we    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (clear) begin
          count_nxt = '0;
          ovf_nxt   = 1'b0;
        end else if (wr_en) begin
          if (count < FULL) begin
            buf_we    = 1'b1;
            count_nxt = count + CW'(1);
          end else begin
            ovf_nxt = 1'b1;
          end
        end
        if (start) begin
          // A same-cycle clear empties the program, so treat it as an empty start
          if (count != '0 && !clear) begin
            loop_nxt  = loop_en;
            rd_nxt    = '0;
            iter_nxt  = '0;
            state_nxt = ST_RUN;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (wr_en) ovf_nxt = 1'b1;
        if (stop) begin
          state_nxt = ST_IDLE;
        end else if (instr_ready) begin
          if (last) begin
            iter_nxt = iter_cnt + 16'd1;
            if (loop_q) begin
              rd_nxt = '0;
            end else begin
              state_nxt = ST_IDLE;
              done_nxt  = 1'b1;
            end
          end else begin
            rd_nxt = rd_ptr + AW'(1);
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Read the buffer at the next pointer so instr_out is a plain register
    out_nxt = (state_nxt == ST_RUN) ? buf_rdata : BUBBLE;
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Pointers, counters, flags and registered instruction output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= '0;
      count     <= '0;
      iter_cnt  <= '0;
      ovf       <= 1'b0;
      loop_q    <= 1'b0;
      done      <= 1'b0;
      instr_out <= BUBBLE;
    end else begin
      rd_ptr    <= rd_nxt;
      count     <= count_nxt;
      iter_cnt  <= iter_nxt;
      ovf       <= ovf_nxt;
      loop_q    <= loop_nxt;
      done      <= done_nxt;
      instr_out <= out_nxt;
    end
  end

  assign instr_valid = (state == ST_RUN);
  assign busy        = (state == ST_RUN);

endmodule
